// File: rtl/riscv_instr_rsp_pkg.sv
// Shared types for the instruction-side memory responder.
package riscv_instr_rsp_pkg;

  // One buffered fetch response.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Per-request tag that travels alongside the SRAM read latency.
  typedef struct packed {
    logic valid;
    logic err;
  } tag_t;

  // Data returned with an access-error response.
  localparam logic [31:0] RSP_ERR_DATA = 32'h0000_0000;

  // True when addr lies in [base, base+span). Evaluated in 33 bits so a
  // window ending at the top of the address space cannot wrap.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [32:0] span);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + span));
  endfunction

endpackage

// File: rtl/riscv_instr_rsp_fifo.sv
// Synchronous response FIFO; pointers wrap at DEPTH so DEPTH need not be a
// power of two. Push and pop may happen in the same cycle.
module riscv_instr_rsp_fifo
  import riscv_instr_rsp_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  rsp_t          i_data,
  input  logic          i_pop,
  output rsp_t          o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream credit scheme must never let a push reach a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule

// File: rtl/riscv_instr_responder.sv
// Instruction fetch slave: grants requests against a credit count, reads a
// fixed-latency SRAM, and returns responses in grant order via a FIFO.
// Handshake: a request transfers in any cycle where instr_req_i and
// instr_gnt_o are both high; a response transfers in every cycle where
// instr_rvalid_o is high (the initiator has no back-pressure).
module riscv_instr_responder
  import riscv_instr_rsp_pkg::*;
#(
  parameter  logic [31:0] MEM_BASE   = 32'h1C00_0000,
  parameter  int unsigned MEM_WORDS  = 8192,
  parameter  int unsigned LATENCY    = 1,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          stall_i,
  input  logic          rsp_stall_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  // Requests in the latency pipe plus entries held in the FIFO.
  logic [CW-1:0] r_outstanding;
  tag_t          r_tag [LATENCY];

  logic          w_in_range;
  logic          w_gnt;
  logic          w_pop;
  tag_t          w_tail;
  rsp_t          w_push_data;
  rsp_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_fifo_count;

  assign w_in_range = addr_in_window(instr_addr_i, MEM_BASE, SPAN);
  // Credit check uses the registered count; a same-cycle pop frees nothing.
  assign w_gnt      = instr_req_i & ~stall_i & ~rst & (r_outstanding < CW'(FIFO_DEPTH));

  assign instr_gnt_o = w_gnt;
  assign mem_req_o   = w_gnt & w_in_range;
  assign mem_addr_o  = AW'((instr_addr_i - MEM_BASE) >> 2);

  // The tag leaving the last stage lines up with the SRAM data for it.
  assign w_tail            = r_tag[LATENCY-1];
  assign w_push_data.err   = w_tail.err;
  assign w_push_data.rdata = w_tail.err ? RSP_ERR_DATA : mem_rdata_i;

  assign w_pop          = ~w_empty & ~rsp_stall_i & ~rst;
  assign instr_rvalid_o = w_pop;
  assign instr_rdata_o  = w_pop ? w_head.rdata : 32'h0;
  assign instr_err_o    = w_pop & w_head.err;
  assign busy_o         = (r_outstanding != '0);

  // Tag pipe: one stage per cycle of SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_gnt, err: w_gnt & ~w_in_range};
      for (int i = 1; i < int'(LATENCY); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Credit counter: +1 on grant, -1 on response pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  riscv_instr_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tail.valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  // The FIFO only ever holds a subset of the outstanding requests.
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst)
    (w_fifo_count <= r_outstanding) && (!w_full || r_outstanding == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_riscv_instr_responder.sv
// Directed bench for riscv_instr_responder: one instance at LATENCY=1 and
// one at LATENCY=3, each with a behavioural SRAM and a response scoreboard.
module tb_riscv_instr_responder;

  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam int          AW   = 13;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic rst3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req1, stall1, rsp_stall1, gnt1, rvalid1, err1, mem_req1, busy1;
  logic [31:0]   addr1, rdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;

  logic          req3, stall3, rsp_stall3, gnt3, rvalid3, err3, mem_req3, busy3;
  logic [31:0]   addr3, rdata3, mem_rdata3;
  logic [AW-1:0] mem_addr3;
  logic [31:0]   d3_0, d3_1, d3_2;

  riscv_instr_responder #(
    .MEM_BASE (BASE), .MEM_WORDS (8192), .LATENCY (1), .FIFO_DEPTH (4)
  ) dut1 (
    .clk (clk), .rst (rst),
    .instr_req_i (req1), .instr_addr_i (addr1), .instr_gnt_o (gnt1),
    .instr_rvalid_o (rvalid1), .instr_rdata_o (rdata1), .instr_err_o (err1),
    .stall_i (stall1), .rsp_stall_i (rsp_stall1),
    .mem_req_o (mem_req1), .mem_addr_o (mem_addr1), .mem_rdata_i (mem_rdata1),
    .busy_o (busy1)
  );

  riscv_instr_responder #(
    .MEM_BASE (BASE), .MEM_WORDS (8192), .LATENCY (3), .FIFO_DEPTH (4)
  ) dut3 (
    .clk (clk), .rst (rst3),
    .instr_req_i (req3), .instr_addr_i (addr3), .instr_gnt_o (gnt3),
    .instr_rvalid_o (rvalid3), .instr_rdata_o (rdata3), .instr_err_o (err3),
    .stall_i (stall3), .rsp_stall_i (rsp_stall3),
    .mem_req_o (mem_req3), .mem_addr_o (mem_addr3), .mem_rdata_i (mem_rdata3),
    .busy_o (busy3)
  );

  // ---------------- SRAM models ----------------
  function automatic logic [31:0] mem_val(input logic [AW-1:0] idx);
    if (idx == AW'(2)) return 32'hDEAD_BEEF;
    return (32'(idx) * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_req1) mem_rdata1 <= mem_val(mem_addr1);
  end

  always @(posedge clk) begin
    d3_0 <= mem_req3 ? mem_val(mem_addr3) : 32'hBAD0_BAD0;
    d3_1 <= d3_0;
    d3_2 <= d3_1;
  end
  assign mem_rdata3 = d3_2;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp3_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Expected {err, rdata} for a fetch address, from the bench's own window rule.
  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    if (a >= BASE && a < BASE + 32'h0000_8000)
      return {1'b0, mem_val(AW'((a - BASE) >> 2))};
    return {1'b1, 32'h0};
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    if (gnt1) exp_q.push_back(exp_rsp(addr1));
    if (rvalid1) begin
      if (exp_q.size() == 0) check("rsp1_unexpected", 64'(rvalid1), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("rsp1_data", 64'({err1, rdata1}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst3) exp3_q.delete();
    if (gnt3) exp3_q.push_back(exp_rsp(addr3));
    if (rvalid3) begin
      if (exp3_q.size() == 0) check("rsp3_unexpected", 64'(rvalid3), 64'd0);
      else begin
        e = exp3_q.pop_front();
        check("rsp3_data", 64'({err3, rdata3}), 64'(e));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle1(input int n);
    req1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t3_addr [7];
  logic        t3_mreq [7];
  logic [12:0] t3_maddr[7];
  int          k;

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    req1 = 1'b1; addr1 = BASE; stall1 = 1'b0; rsp_stall1 = 1'b0;
    req3 = 1'b1; addr3 = BASE; stall3 = 1'b0; rsp_stall3 = 1'b0;

    // Reset values, with requests held high to show grants are gated.
    tick();
    smp();
    check("rst_gnt",    64'(gnt1),    64'd0);
    check("rst_rvalid", 64'(rvalid1), 64'd0);
    check("rst_rdata",  64'(rdata1),  64'd0);
    check("rst_err",    64'(err1),    64'd0);
    check("rst_memreq", 64'(mem_req1), 64'd0);
    check("rst_busy",   64'(busy1),   64'd0);
    check("rst3_gnt",   64'(gnt3),    64'd0);
    check("rst3_busy",  64'(busy3),   64'd0);
    tick();
    rst = 1'b0; rst3 = 1'b0; req3 = 1'b0;
    idle1(2);

    // Single read of word 2: grant at T, rvalid at T+2.
    req1 = 1'b1; addr1 = BASE + 32'h8;
    smp();
    check("t1_gnt",     64'(gnt1),      64'd1);
    check("t1_memreq",  64'(mem_req1),  64'd1);
    check("t1_memaddr", 64'(mem_addr1), 64'd2);
    check("t1_rv_T",    64'(rvalid1),   64'd0);
    tick();
    req1 = 1'b0;
    smp();
    check("t1_rv_T1",   64'(rvalid1),   64'd0);
    check("t1_busy_T1", 64'(busy1),     64'd1);
    tick();
    smp();
    check("t1_rv_T2",   64'(rvalid1),   64'd1);
    check("t1_rdata",   64'(rdata1),    64'hDEAD_BEEF);
    check("t1_err",     64'(err1),      64'd0);
    tick();
    smp();
    check("t1_busy_end", 64'(busy1),    64'd0);
    idle1(2);

    // 16 back-to-back reads.
    for (int c = 0; c < 20; c++) begin
      req1  = (c < 16);
      addr1 = BASE + 32'(4 * (100 + c));
      smp();
      check("t2_gnt",    64'(gnt1),   64'(c < 16));
      check("t2_rvalid", 64'(rvalid1), 64'(c >= 2 && c < 18));
      check("t2_busy",   64'(busy1),  64'(c >= 1 && c < 18));
      tick();
    end
    idle1(2);

    // Error responses mixed with reads, plus window boundaries.
    t3_addr  = '{BASE + 32'h40, 32'h0, BASE + 32'h44, BASE + 32'h8000,
                 BASE + 32'h7FFC, BASE - 32'h4, BASE + 32'h4B};
    t3_mreq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t3_maddr = '{13'd16, 13'd0, 13'd17, 13'd0, 13'd8191, 13'd0, 13'd18};
    for (int c = 0; c < 7; c++) begin
      req1  = 1'b1;
      addr1 = t3_addr[c];
      smp();
      check("t3_gnt",    64'(gnt1),     64'd1);
      check("t3_memreq", 64'(mem_req1), 64'(t3_mreq[c]));
      if (t3_mreq[c]) check("t3_memaddr", 64'(mem_addr1), 64'(t3_maddr[c]));
      tick();
    end
    idle1(6);
    smp();
    check("t3_busy_end", 64'(busy1), 64'd0);
    tick();

    // Response stall fills the FIFO; grants resume after the first pop.
    k = 0;
    for (int c = 0; c < 17; c++) begin
      rsp_stall1 = (c < 10);
      req1       = (c <= 11);
      addr1      = BASE + 32'(4 * (200 + k));
      smp();
      check("t4_gnt",    64'(gnt1),    64'(c < 4 || c == 11));
      check("t4_rvalid", 64'(rvalid1), 64'(c >= 10 && c <= 14));
      check("t4_busy",   64'(busy1),   64'(c >= 1 && c <= 14));
      if (c < 4 || c == 11) k++;
      tick();
    end
    rsp_stall1 = 1'b0;
    idle1(2);

    // Grant stall: nothing issued while stall_i is high.
    for (int c = 0; c < 8; c++) begin
      stall1 = (c < 3);
      req1   = (c <= 3);
      addr1  = BASE + 32'h100;
      smp();
      check("t5_gnt",    64'(gnt1),     64'(c == 3));
      check("t5_memreq", 64'(mem_req1), 64'(c == 3));
      check("t5_rvalid", 64'(rvalid1),  64'(c == 5));
      check("t5_busy",   64'(busy1),    64'(c >= 4 && c <= 5));
      tick();
    end
    stall1 = 1'b0;
    idle1(2);

    // LATENCY=3: reset with three requests in flight, then a normal read.
    for (int c = 0; c < 16; c++) begin
      req3  = (c <= 3) || (c == 10);
      rst3  = (c == 3);
      addr3 = (c == 10) ? BASE + 32'h8 : BASE + 32'(4 * (400 + c));
      smp();
      check("t6_gnt",    64'(gnt3),    64'(c < 3 || c == 10));
      check("t6_rvalid", 64'(rvalid3), 64'(c == 14));
      check("t6_busy",   64'(busy3),   64'((c >= 1 && c <= 3) || (c >= 11 && c <= 14)));
      if (c == 14) check("t6_rdata", 64'(rdata3), 64'hDEAD_BEEF);
      tick();
    end
    req3 = 1'b0; rst3 = 1'b0;
    tick();

    check("q1_drained", 64'(exp_q.size()),  64'd0);
    check("q3_drained", 64'(exp3_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
